// File: rtl/cl_serializer_if.sv
// Bundle for the cl_serializer request/result handshake and its serial link to the cl_ unit.
interface cl_serializer_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic [2:0]       i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_bit1;
    logic             o_bit2;
    logic             i_and;
    logic             i_nand;
    logic             i_or;
    logic             i_nor;
    logic             i_xor;
    logic             i_xnor;
    logic             i_not;
    logic             o_busy;
    logic             o_done;
    logic             o_err;
    logic [WIDTH-1:0] o_result;

    modport slave (
        input  i_start, i_op, i_a, i_b,
        input  i_and, i_nand, i_or, i_nor, i_xor, i_xnor, i_not,
        output o_bit1, o_bit2, o_busy, o_done, o_err, o_result
    );

    modport master (
        output i_start, i_op, i_a, i_b,
        output i_and, i_nand, i_or, i_nor, i_xor, i_xnor, i_not,
        input  o_bit1, o_bit2, o_busy, o_done, o_err, o_result
    );
endinterface

// File: rtl/cl_serializer.sv
// Bit-serial operand sequencer: streams two WIDTH-bit operands LSB-first into the cl_ unit
// and reassembles the opcode-selected cl_ output into a result word.
module cl_serializer #(
    parameter int WIDTH = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    cl_serializer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] result;
    logic [CW-1:0]    cnt;
    logic             sel;
    logic             load;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                load       = bus.i_start;
                state_next = bus.i_start ? SHIFT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Op 7 falls through to the default so an invalid opcode assembles all zeros.
    always_comb begin
        sel = 1'b0;
        case (op_r)
            3'd0:    sel = bus.i_and;
            3'd1:    sel = bus.i_nand;
            3'd2:    sel = bus.i_or;
            3'd3:    sel = bus.i_nor;
            3'd4:    sel = bus.i_xor;
            3'd5:    sel = bus.i_xnor;
            3'd6:    sel = bus.i_not;
            default: sel = 1'b0;
        endcase
    end

    assign acc_next = {sel, acc[WIDTH-1:1]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sh_a   <= '0;
            sh_b   <= '0;
            op_r   <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (load) begin
            sh_a <= bus.i_a;
            sh_b <= bus.i_b;
            op_r <= bus.i_op;
            acc  <= '0;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            acc  <= acc_next;
            cnt  <= cnt + CNT_ONE;
            // Capture the last selected bit directly so the result is ready on DONE entry.
            if (cnt == LAST) result <= acc_next;
        end
    end

    assign bus.o_busy   = (state == SHIFT);
    assign bus.o_done   = (state == DONE);
    assign bus.o_err    = (state == DONE) && (op_r == 3'd7);
    assign bus.o_bit1   = (state == SHIFT) && sh_a[0];
    assign bus.o_bit2   = (state == SHIFT) && sh_b[0];
    assign bus.o_result = result;
endmodule
